pulse_pair_gen: RTL and testbench

Downstream consumer of the stepped 9-bit counter. Each accepted count word is turned into a timed pulse pair: pulse `a`, then an idle gap, then pulse `b`. The widths and the gap are decoded from bit fields of the word. A 2-deep input buffer lets the counter stage run ahead while a pulse pair is in progress. A wrapping completion counter gives the bench and downstream logic a running total.

---
 rtl/pulse_pair_gen_if.sv | 11 +
 rtl/pulse_pair_gen.sv | 139 +++++++++++++
 tb/tb_pulse_pair_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pulse_pair_gen_if.sv
// Count-word handshake between the counter stage (master) and pulse_pair_gen (slave).
interface pulse_pair_gen_if #(
  parameter int unsigned CW = 9
);
  logic          cnt_valid;
  logic [CW-1:0] cnt_data;
  logic          cnt_ready;

  modport master (output cnt_valid, output cnt_data, input cnt_ready);
  modport slave  (input cnt_valid, input cnt_data, output cnt_ready);
endinterface

// File: rtl/pulse_pair_gen.sv
// Turns buffered count words into an a-pulse / gap / b-pulse sequence whose
// widths come from bit fields of the word; counts completed pairs.
module pulse_pair_gen #(
  parameter int unsigned CW    = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_pair_gen_if.slave       cnt_if,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pair_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam int unsigned TW = 5;

  typedef enum logic [1:0] {IDLE, PA, GAP, PB} state_t;

  logic [CW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic [1:0]    r_g;
  logic [3:0]    r_wb;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_head;

  assign w_full           = (r_occ == OW'(DEPTH));
  assign w_empty          = (r_occ == '0);
  assign cnt_if.cnt_ready = !w_full;
  assign w_push           = cnt_if.cnt_valid && !w_full;
  assign w_head           = r_mem[r_rd_ptr];
  // The FSM takes the head word whenever it is idle or finishing a b pulse.
  assign w_pop            = !w_empty &&
                            ((r_state == IDLE) || ((r_state == PB) && (r_cnt == '0)));

  // Buffer storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cnt_if.cnt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Phase sequencer; r_cnt holds remaining cycles minus one for the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_g      <= '0;
      r_wb     <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pair_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: ;
        PA: begin
          if (r_cnt == '0) begin
            a <= 1'b0;
            if (r_g != 2'd0) begin
              r_state <= GAP;
              r_cnt   <= TW'(r_g) - TW'(1);
            end else begin
              r_state <= PB;
              r_cnt   <= TW'(r_wb);
              b       <= 1'b1;
              done    <= (r_wb == 4'd0);
            end
          end else begin
            r_cnt <= r_cnt - TW'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= PB;
            r_cnt   <= TW'(r_wb);
            b       <= 1'b1;
            done    <= (r_wb == 4'd0);
          end else begin
            r_cnt <= r_cnt - TW'(1);
          end
        end
        PB: begin
          if (r_cnt == '0) begin
            r_state  <= IDLE;
            b        <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            pair_cnt <= pair_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt - TW'(1);
            done  <= (r_cnt == TW'(1));
          end
        end
        default: r_state <= IDLE;
      endcase

      // A pop overrides the end-of-pair defaults so back-to-back words have no gap.
      if (w_pop) begin
        r_state <= PA;
        r_cnt   <= TW'(w_head[4:2]);
        r_g     <= w_head[1:0];
        r_wb    <= w_head[8:5];
        a       <= 1'b1;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Directed bench for pulse_pair_gen: traces outputs per cycle and compares
// against hand-derived cycle masks.
module tb_pulse_pair_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a, b, busy, done;
  logic [7:0] pair_cnt;

  pulse_pair_gen_if #(.CW(9)) cnt_if ();

  pulse_pair_gen #(.CW(9), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_if   (cnt_if.slave),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .pair_cnt (pair_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0]  q[$];
  logic [63:0] tr_a, tr_b, tr_d, tr_busy, tr_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    cnt_if.cnt_valid = 1'b0;
    cnt_if.cnt_data  = '0;
    q.delete();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Bit k of each trace = output value in the cycle after the k-th edge from the start.
  task automatic trace(input int n);
    logic acc;
    tr_a = '0; tr_b = '0; tr_d = '0; tr_busy = '0; tr_rdy = '0;
    for (int k = 0; k < n; k++) begin
      cnt_if.cnt_valid = (q.size() > 0);
      cnt_if.cnt_data  = (q.size() > 0) ? q[0] : 9'h000;
      #1;
      acc = cnt_if.cnt_valid && cnt_if.cnt_ready;
      @(posedge clk);
      #1;
      if (acc) void'(q.pop_front());
      tr_a[k]    = a;
      tr_b[k]    = b;
      tr_d[k]    = done;
      tr_busy[k] = busy;
      tr_rdy[k]  = cnt_if.cnt_ready;
    end
    cnt_if.cnt_valid = 1'b0;
  endtask

  initial begin
    int  ndone;
    logic acc;

    // Reset state
    do_reset();
    check("rst_a",        64'(a),                1'b0);
    check("rst_b",        64'(b),                1'b0);
    check("rst_busy",     64'(busy),             1'b0);
    check("rst_done",     64'(done),             1'b0);
    check("rst_pair_cnt", 64'(pair_cnt),         64'd0);
    check("rst_ready",    64'(cnt_if.cnt_ready), 64'd1);

    // 0x0A5: WA=2 G=1 WB=6
    do_reset();
    q.push_back(9'h0A5);
    trace(11);
    check("w0a5_a",    tr_a,    m(1, 2));
    check("w0a5_b",    tr_b,    m(4, 9));
    check("w0a5_done", tr_d,    m(9, 9));
    check("w0a5_busy", tr_busy, m(1, 9));
    check("w0a5_cnt",  64'(pair_cnt), 64'd1);

    // 0x000: WA=1 G=0 WB=1
    do_reset();
    q.push_back(9'h000);
    trace(4);
    check("w000_a",    tr_a,    m(1, 1));
    check("w000_b",    tr_b,    m(2, 2));
    check("w000_done", tr_d,    m(2, 2));
    check("w000_busy", tr_busy, m(1, 2));
    check("w000_cnt",  64'(pair_cnt), 64'd1);

    // Three words on consecutive edges: 27 + 2 + 9 cycles back to back
    do_reset();
    q.push_back(9'h1FF);
    q.push_back(9'h000);
    q.push_back(9'h0A5);
    trace(40);
    check("b2b_a",     tr_a,    m(1, 8) | m(28, 28) | m(30, 31));
    check("b2b_b",     tr_b,    m(12, 27) | m(29, 29) | m(33, 38));
    check("b2b_done",  tr_d,    m(27, 27) | m(29, 29) | m(38, 38));
    check("b2b_busy",  tr_busy, m(1, 38));
    check("b2b_ready", tr_rdy,  m(0, 1) | m(28, 39));
    check("b2b_cnt",   64'(pair_cnt), 64'd3);
    check("b2b_qempty", 64'(q.size()), 64'd0);

    // Reset during cycle 5 of a
    do_reset();
    q.push_back(9'h1FF);
    trace(6);
    check("trunc_a_pre", tr_a, m(1, 5));
    rst_n = 1'b0;
    #1;
    check("trunc_a",     64'(a),                64'd0);
    check("trunc_done",  64'(done),             64'd0);
    check("trunc_busy",  64'(busy),             64'd0);
    check("trunc_cnt",   64'(pair_cnt),         64'd0);
    check("trunc_ready", 64'(cnt_if.cnt_ready), 64'd1);
    #1;
    rst_n = 1'b1;
    trace(4);
    check("trunc_after_a",    tr_a,    64'd0);
    check("trunc_after_busy", tr_busy, 64'd0);
    check("trunc_after_done", tr_d,    64'd0);

    // 256 minimal words with valid held high: pair_cnt wraps to 0
    do_reset();
    for (int i = 0; i < 256; i++) q.push_back(9'h000);
    ndone = 0;
    for (int cyc = 0; cyc < 2000 && ndone < 256; cyc++) begin
      cnt_if.cnt_valid = (q.size() > 0);
      cnt_if.cnt_data  = 9'h000;
      #1;
      acc = cnt_if.cnt_valid && cnt_if.cnt_ready;
      @(posedge clk);
      #1;
      if (acc) void'(q.pop_front());
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 256) check("wrap_pre", 64'(pair_cnt), 64'd255);
      end
    end
    cnt_if.cnt_valid = 1'b0;
    check("wrap_ndone", 64'(ndone), 64'd256);
    @(posedge clk);
    #1;
    check("wrap_cnt",  64'(pair_cnt), 64'd0);
    check("wrap_done", 64'(done),     64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
